// File: rtl/hdmi_timing_gen_if.sv
// Raster timing bundle between the timing generator and its consumers.
// The generator takes the master modport. Display driver and transmitter logic take the slave modport.
interface hdmi_timing_gen_if #(
  parameter int CNT_W = 10
);
  logic             en;
  logic             HDMI_DE;
  logic             HDMI_HSYNC;
  logic             HDMI_VSYNC;
  logic [CNT_W-1:0] h_count;
  logic [CNT_W-1:0] v_count;
  logic             line_start;
  logic             frame_start;
  logic             vblank;

  modport master (
    input  en,
    output HDMI_DE, HDMI_HSYNC, HDMI_VSYNC,
    output h_count, v_count, line_start, frame_start, vblank
  );

  modport slave (
    output en,
    input  HDMI_DE, HDMI_HSYNC, HDMI_VSYNC,
    input  h_count, v_count, line_start, frame_start, vblank
  );
endinterface

// File: rtl/hdmi_timing_gen.sv
// HDMI raster timing generator: pixel/line counters plus DE, HSYNC, VSYNC and strobes.
// Every output is registered and is decoded from the next counter values, so it describes the same pixel as h_count/v_count.
module hdmi_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CNT_W    = 10
) (
  input  logic               clk_hdmi,
  input  logic               rst,
  hdmi_timing_gen_if.master  tif
);

  typedef enum logic [1:0] {R_ACTIVE, R_FRONT, R_SYNC, R_BACK} region_t;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_FP_START   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_BP_START   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_FP_START   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_BP_START   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  function automatic region_t decode_region(
    input logic [CNT_W-1:0] cnt,
    input logic [CNT_W-1:0] fp_start,
    input logic [CNT_W-1:0] sync_start,
    input logic [CNT_W-1:0] bp_start
  );
    if (cnt < fp_start)        return R_ACTIVE;
    else if (cnt < sync_start) return R_FRONT;
    else if (cnt < bp_start)   return R_SYNC;
    else                       return R_BACK;
  endfunction

  logic [CNT_W-1:0] h_count_reg, h_count_next;
  logic [CNT_W-1:0] v_count_reg, v_count_next;
  region_t          h_region_next, v_region_next;
  logic             h_wrap;

  logic de_reg, de_next;
  logic hsync_reg, hsync_next;
  logic vsync_reg, vsync_next;
  logic line_start_reg, line_start_next;
  logic frame_start_reg, frame_start_next;
  logic vblank_reg, vblank_next;

  // State register: counters plus the output flops, all cleared asynchronously.
  always_ff @(posedge clk_hdmi or posedge rst) begin
    if (rst) begin
      h_count_reg     <= H_LAST;
      v_count_reg     <= V_LAST;
      de_reg          <= 1'b0;
      hsync_reg       <= ~H_POL;
      vsync_reg       <= ~V_POL;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      vblank_reg      <= 1'b1;
    end else begin
      h_count_reg     <= h_count_next;
      v_count_reg     <= v_count_next;
      de_reg          <= de_next;
      hsync_reg       <= hsync_next;
      vsync_reg       <= vsync_next;
      line_start_reg  <= line_start_next;
      frame_start_reg <= frame_start_next;
      vblank_reg      <= vblank_next;
    end
  end

  // Next-state: dropping en parks the counters on the last pixel, so the next enabled edge lands on (0,0).
  always_comb begin
    h_wrap       = (h_count_reg == H_LAST);
    h_count_next = h_wrap ? '0 : h_count_reg + 1'b1;
    v_count_next = v_count_reg;
    if (h_wrap) begin
      v_count_next = (v_count_reg == V_LAST) ? '0 : v_count_reg + 1'b1;
    end
    if (!tif.en) begin
      h_count_next = H_LAST;
      v_count_next = V_LAST;
    end
    h_region_next = decode_region(h_count_next, H_FP_START, H_SYNC_START, H_BP_START);
    v_region_next = decode_region(v_count_next, V_FP_START, V_SYNC_START, V_BP_START);
  end

  // Output decode. v only moves on the h wrap, so VSYNC switches only when h_count==0.
  always_comb begin
    de_next          = (h_region_next == R_ACTIVE) && (v_region_next == R_ACTIVE);
    hsync_next       = (h_region_next == R_SYNC) ? H_POL : ~H_POL;
    vsync_next       = (v_region_next == R_SYNC) ? V_POL : ~V_POL;
    line_start_next  = (h_count_next == '0);
    frame_start_next = (h_count_next == '0) && (v_count_next == '0);
    vblank_next      = (v_region_next != R_ACTIVE);
    if (!tif.en) begin
      de_next          = 1'b0;
      hsync_next       = ~H_POL;
      vsync_next       = ~V_POL;
      line_start_next  = 1'b0;
      frame_start_next = 1'b0;
      vblank_next      = 1'b1;
    end
  end

  assign tif.h_count     = h_count_reg;
  assign tif.v_count     = v_count_reg;
  assign tif.HDMI_DE     = de_reg;
  assign tif.HDMI_HSYNC  = hsync_reg;
  assign tif.HDMI_VSYNC  = vsync_reg;
  assign tif.line_start  = line_start_reg;
  assign tif.frame_start = frame_start_reg;
  assign tif.vblank      = vblank_reg;

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen: a default 640x480 instance and a tiny active-high-sync instance,
// checked against fixed vectors and an arithmetic raster model.
module tb_hdmi_timing_gen;

  logic clk_hdmi = 1'b0;
  logic rst;

  always #5 clk_hdmi = ~clk_hdmi;

  hdmi_timing_gen_if #(.CNT_W(10)) ifa ();
  hdmi_timing_gen_if #(.CNT_W(10)) ifb ();

  hdmi_timing_gen dut_a (
    .clk_hdmi (clk_hdmi),
    .rst      (rst),
    .tif      (ifa)
  );

  hdmi_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .CNT_W(10)
  ) dut_b (
    .clk_hdmi (clk_hdmi),
    .rst      (rst),
    .tif      (ifb)
  );

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic de, hs, vs, ls, fs, vb;
  } obs_t;

  typedef struct {
    int ha, hf, hsw, hb, va, vf, vsw, vb;
    bit hp, vp;
  } cfg_t;

  typedef struct {
    int sel, t, h, v, de, hs, vs, ls, fs, vb;
  } vec_t;

  cfg_t cfg_a, cfg_b;
  vec_t tbl[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   t_a, t_b;  // enabled edges since the last restart; 0 means the reset state

  // Raster position is simply (t-1) modulo the frame size, split into line and column.
  function automatic obs_t model(input cfg_t c, input int t);
    obs_t o;
    int ht, vt, pos, h, v;
    ht = c.ha + c.hf + c.hsw + c.hb;
    vt = c.va + c.vf + c.vsw + c.vb;
    if (t == 0) begin
      o.h = 10'(ht - 1); o.v = 10'(vt - 1);
      o.de = 1'b0; o.hs = ~c.hp; o.vs = ~c.vp;
      o.ls = 1'b0; o.fs = 1'b0; o.vb = 1'b1;
    end else begin
      pos = (t - 1) % (ht * vt);
      h = pos % ht;
      v = pos / ht;
      o.h  = 10'(h);
      o.v  = 10'(v);
      o.de = (h < c.ha) && (v < c.va);
      o.hs = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hsw) ? c.hp : ~c.hp;
      o.vs = (v >= c.va + c.vf && v < c.va + c.vf + c.vsw) ? c.vp : ~c.vp;
      o.ls = (h == 0);
      o.fs = (pos == 0);
      o.vb = (v >= c.va);
    end
    return o;
  endfunction

  function automatic obs_t sample_a();
    obs_t o;
    o.h = ifa.h_count; o.v = ifa.v_count; o.de = ifa.HDMI_DE;
    o.hs = ifa.HDMI_HSYNC; o.vs = ifa.HDMI_VSYNC; o.ls = ifa.line_start;
    o.fs = ifa.frame_start; o.vb = ifa.vblank;
    return o;
  endfunction

  function automatic obs_t sample_b();
    obs_t o;
    o.h = ifb.h_count; o.v = ifb.v_count; o.de = ifb.HDMI_DE;
    o.hs = ifb.HDMI_HSYNC; o.vs = ifb.HDMI_VSYNC; o.ls = ifb.line_start;
    o.fs = ifb.frame_start; o.vb = ifb.vblank;
    return o;
  endfunction

  task automatic chk(input string name, input obs_t got, input obs_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b vb=%b, expected h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b vb=%b",
               name, got.h, got.v, got.de, got.hs, got.vs, got.ls, got.fs, got.vb,
               exp.h, exp.v, exp.de, exp.hs, exp.vs, exp.ls, exp.fs, exp.vb);
    end
  endtask

  // One clock edge, then both instances compared with the model 1 time unit later.
  task automatic step();
    @(posedge clk_hdmi);
    if (rst) begin
      t_a = 0; t_b = 0;
    end else begin
      t_a = ifa.en ? t_a + 1 : 0;
      t_b = ifb.en ? t_b + 1 : 0;
    end
    #1;
    chk($sformatf("model_a t=%0d", t_a), sample_a(), model(cfg_a, t_a));
    chk($sformatf("model_b t=%0d", t_b), sample_b(), model(cfg_b, t_b));
  endtask

  // Reset pulse between clock edges; the outputs must clear before any edge arrives.
  task automatic async_reset();
    #1 rst = 1'b1;
    #1;
    chk("async_rst_a", sample_a(), model(cfg_a, 0));
    chk("async_rst_b", sample_b(), model(cfg_b, 0));
    t_a = 0; t_b = 0;
    #1 rst = 1'b0;
  endtask

  initial begin
    obs_t exp, m;
    vec_t r;
    int guard;

    cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    cfg_b = '{8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1};

    // Fields: sel, t, h, v, de, hs, vs, ls, fs, vb. The rows are kept in ascending t order.
    tbl.push_back('{0,   0, 799, 524, 0, 1, 1, 0, 0, 1});
    tbl.push_back('{1,   0,  13,   6, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{0,   1,   0,   0, 1, 1, 1, 1, 1, 0});
    tbl.push_back('{1,   1,   0,   0, 1, 0, 0, 1, 1, 0});
    tbl.push_back('{1,   8,   7,   0, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{1,   9,   8,   0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1,  11,  10,   0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{1,  12,  11,   0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{1,  13,  12,   0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1,  15,   0,   1, 1, 0, 0, 1, 0, 0});
    tbl.push_back('{1,  71,   0,   5, 0, 0, 1, 1, 0, 1});
    tbl.push_back('{1,  84,  13,   5, 0, 0, 1, 0, 0, 1});
    tbl.push_back('{1,  85,   0,   6, 0, 0, 0, 1, 0, 1});
    tbl.push_back('{1,  99,   0,   0, 1, 0, 0, 1, 1, 0});
    tbl.push_back('{0, 640, 639,   0, 1, 1, 1, 0, 0, 0});
    tbl.push_back('{0, 641, 640,   0, 0, 1, 1, 0, 0, 0});
    tbl.push_back('{0, 656, 655,   0, 0, 1, 1, 0, 0, 0});
    tbl.push_back('{0, 657, 656,   0, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{0, 752, 751,   0, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{0, 753, 752,   0, 0, 1, 1, 0, 0, 0});
    tbl.push_back('{0, 800, 799,   0, 0, 1, 1, 0, 0, 0});
    tbl.push_back('{0, 801,   0,   1, 1, 1, 1, 1, 0, 0});

    rst = 1'b1; ifa.en = 1'b1; ifb.en = 1'b1; t_a = 0; t_b = 0;
    repeat (2) @(posedge clk_hdmi);
    #1 rst = 1'b0;

    // Fixed vectors against hand-derived values.
    foreach (tbl[i]) begin
      r = tbl[i];
      guard = 0;
      while (t_a < r.t && guard < 1000) begin
        step();
        guard++;
      end
      exp.h = 10'(r.h); exp.v = 10'(r.v);
      exp.de = 1'(r.de); exp.hs = 1'(r.hs); exp.vs = 1'(r.vs);
      exp.ls = 1'(r.ls); exp.fs = 1'(r.fs); exp.vb = 1'(r.vb);
      if (r.sel == 0) chk($sformatf("table_a t=%0d", r.t), sample_a(), exp);
      else            chk($sformatf("table_b t=%0d", r.t), sample_b(), exp);
    end

    // Drop en on the default instance at h=300, v=2 for 5 cycles.
    guard = 0;
    while (t_a != 2 * 800 + 300 + 1 && guard < 2000) begin
      step();
      guard++;
    end
    ifa.en = 1'b0;
    repeat (5) step();
    ifa.en = 1'b1;
    step();
    exp = '{h: 10'd0, v: 10'd0, de: 1'b1, hs: 1'b1, vs: 1'b1, ls: 1'b1, fs: 1'b1, vb: 1'b0};
    chk("en_restart_a", sample_a(), exp);

    // Async reset in the middle of the small instance's sync line (v=5).
    guard = 0;
    m = model(cfg_b, t_b);
    while (!(m.v == 10'd5 && m.h == 10'd3) && guard < 200) begin
      step();
      m = model(cfg_b, t_b);
      guard++;
    end
    vectors++;
    if (guard >= 200) begin
      miscompares++;
      $display("FAIL reach_vsync_b: got no v=5 h=3 within 200 cycles, expected it within one frame");
    end
    chk("pre_rst_vsync_b", sample_b(), model(cfg_b, t_b));
    async_reset();
    exp = '{h: 10'd13, v: 10'd6, de: 1'b0, hs: 1'b0, vs: 1'b0, ls: 1'b0, fs: 1'b0, vb: 1'b1};
    chk("rst_values_b", sample_b(), exp);
    repeat (200) step();

    // Random en drops and reset pulses, checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      ifa.en = ($urandom_range(0, 199) != 0);
      ifb.en = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 699) == 0) async_reset();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
